// File: rtl/switch_evt_pkg.sv
// rtl/switch_evt_pkg.sv - shared constants, index-width helper and event type for the switch event conditioner
package switch_evt_pkg;

    localparam int MAX_CH    = 32;
    localparam int MAX_IDX_W = $clog2(MAX_CH);

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } evt_t;

endpackage

// File: rtl/switch_debounce_ch.sv
// rtl/switch_debounce_ch.sv - one switch channel: synchroniser, debounce, press/release pulses
// Hold/auto-repeat counter is built only when SWITCH_EVT_AUTOREPEAT_EN is defined.
module switch_debounce_ch #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic rpt
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
        end
    end

    // Any cycle agreeing with the accepted level restarts the stability count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt + 1'b1 == CNT_LAST) begin
                cnt           <= '0;
                level         <= ~level;
                press         <= ~level;
                release_pulse <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SWITCH_EVT_AUTOREPEAT_EN
    localparam int                HOLD_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                HOLD_W      = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_cnt;
    logic              repeating;

    // First repeat after the initial delay, then at the shorter period while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
            rpt       <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (!level) begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
            end else if (hold_cnt + 1'b1 == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
                hold_cnt  <= '0;
                repeating <= 1'b1;
                rpt       <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt               = 1'b0;
`endif

endmodule

// File: rtl/switch_event_conditioner.sv
// rtl/switch_event_conditioner.sv - N_CH debounced switches merged into a lowest-index-first event port
// Optional auto-repeat on held switches with SWITCH_EVT_AUTOREPEAT_EN.
module switch_event_conditioner
    import switch_evt_pkg::*;
#(
    parameter int N_CH            = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH-1:0]            sw,
    output logic [N_CH-1:0]            sw_level,
    output logic [N_CH-1:0]            sw_press,
    output logic [N_CH-1:0]            sw_release,
    output logic                       evt_valid,
    output logic [idx_width(N_CH)-1:0] evt_idx,
    input  logic                       evt_ready,
    output logic                       evt_overflow
);

    localparam int IDX_W = idx_width(N_CH);

    logic [N_CH-1:0] rpt;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] set_vec;
    logic [N_CH-1:0] clr_vec;
    evt_t            evt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        switch_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .sw           (sw[i]),
            .level        (sw_level[i]),
            .press        (sw_press[i]),
            .release_pulse(sw_release[i]),
            .rpt          (rpt[i])
        );
    end

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        evt = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                evt.valid = 1'b1;
                evt.idx   = MAX_IDX_W'(i);
            end
        end
    end

    assign evt_valid = evt.valid;
    assign evt_idx   = IDX_W'(evt.idx);

    always_comb begin
        clr_vec = '0;
        if (evt_valid && evt_ready) begin
            clr_vec[evt_idx] = 1'b1;
        end
    end

    assign set_vec = sw_press | rpt;

    // A set on a bit being accepted in the same cycle is a fresh event, not a merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend         <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pend <= (pend & ~clr_vec) | set_vec;
            if (|(set_vec & pend & ~clr_vec)) begin
                evt_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_event_conditioner.sv
// tb/tb_switch_event_conditioner.sv - self-checking bench for switch_event_conditioner
module tb_switch_event_conditioner;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sw = '0;
    logic         evt_ready = 1'b0;
    logic [N-1:0] sw_level, sw_press, sw_release;
    logic         evt_valid;
    logic [2:0]   evt_idx;
    logic         evt_overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic cmp_en = 1'b0;

    int n_press0 = 0;
    int n_rel0   = 0;
    int evt_times[$];

    always #5 clk = ~clk;

    switch_event_conditioner #(
        .N_CH           (N),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .sw_level    (sw_level),
        .sw_press    (sw_press),
        .sw_release  (sw_release),
        .evt_valid   (evt_valid),
        .evt_idx     (evt_idx),
        .evt_ready   (evt_ready),
        .evt_overflow(evt_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sync as a pure delay line, debounce as a run length of disagreeing samples.
    logic [N-1:0] m_dly [SS];
    logic [N-1:0] m_lvl, m_press, m_rel, m_rpt, m_pend;
    logic [N-1:0] s_now, set_v, clr_v;
    logic         m_ovf;
    int           m_run [N];
    int           m_hold [N];

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int k = 0; k < SS; k++) m_dly[k] = '0;
                m_lvl = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_pend = '0; m_ovf = 1'b0;
                for (int i = 0; i < N; i++) begin
                    m_run[i]  = 0;
                    m_hold[i] = 0;
                end
            end else begin
                set_v = m_press | m_rpt;
                clr_v = '0;
                if (m_pend != 0 && evt_ready) clr_v[lowest(m_pend)] = 1'b1;
                if ((set_v & m_pend & ~clr_v) != 0) m_ovf = 1'b1;
                m_pend = (m_pend & ~clr_v) | set_v;
                s_now = m_dly[SS-1];
                for (int k = SS - 1; k > 0; k--) m_dly[k] = m_dly[k-1];
                m_dly[0] = sw;
                m_press = '0; m_rel = '0; m_rpt = '0;
                for (int i = 0; i < N; i++) begin
`ifdef SWITCH_EVT_AUTOREPEAT_EN
                    if (m_lvl[i]) begin
                        m_hold[i]++;
                        if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RP == 0))
                            m_rpt[i] = 1'b1;
                    end else begin
                        m_hold[i] = 0;
                    end
`endif
                    if (s_now[i] != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_run[i] = 0;
                            m_lvl[i] = ~m_lvl[i];
                            if (m_lvl[i]) m_press[i] = 1'b1;
                            else          m_rel[i]   = 1'b1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && cmp_en) begin
                check("level",    32'(sw_level),     32'(m_lvl));
                check("press",    32'(sw_press),     32'(m_press));
                check("release",  32'(sw_release),   32'(m_rel));
                check("valid",    32'(evt_valid),    32'(m_pend != 0));
                check("idx",      32'(evt_idx),      32'(lowest(m_pend)));
                check("overflow", 32'(evt_overflow), 32'(m_ovf));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            n_press0 += int'(sw_press[0]);
            n_rel0   += int'(sw_release[0]);
            if (evt_valid && evt_ready) evt_times.push_back(cyc);
        end
    endtask

    initial begin
        @(negedge clk);
        check("rst_level",    32'(sw_level),     32'h0);
        check("rst_press",    32'(sw_press),     32'h0);
        check("rst_valid",    32'(evt_valid),    32'h0);
        check("rst_idx",      32'(evt_idx),      32'h0);
        check("rst_overflow", 32'(evt_overflow), 32'h0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        tick(2);

        // latency
        sw[3] = 1'b1;
        tick(5);
        check("lat_level_early", 32'(sw_level), 32'h00);
        tick(1);
        check("lat_level", 32'(sw_level), 32'h08);
        check("lat_press", 32'(sw_press), 32'h08);
        check("lat_valid_early", 32'(evt_valid), 32'h0);
        tick(1);
        check("lat_press_once", 32'(sw_press), 32'h00);
        check("lat_valid", 32'(evt_valid), 32'h1);
        check("lat_idx", 32'(evt_idx), 32'h3);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("lat_drain", 32'(evt_valid), 32'h0);
        sw[3] = 1'b0;
        tick(10);

        // glitch rejection
        n_press0 = 0; n_rel0 = 0;
        sw[0] = 1'b1; tick(3);
        sw[0] = 1'b0; tick(10);
        check("glitch_press", 32'(n_press0), 32'd0);
        check("glitch_release", 32'(n_rel0), 32'd0);
        check("glitch_valid", 32'(evt_valid), 32'h0);
        sw[0] = 1'b1; tick(6);
        sw[0] = 1'b0; tick(12);
        check("pulse6_press", 32'(n_press0), 32'd1);
        check("pulse6_release", 32'(n_rel0), 32'd1);
        check("pulse6_valid", 32'(evt_valid), 32'h1);
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;

        // ordering
        evt_ready = 1'b1;
        sw[5] = 1'b1; sw[2] = 1'b1;
        tick(7);
        check("ord_first_valid", 32'(evt_valid), 32'h1);
        check("ord_first_idx", 32'(evt_idx), 32'h2);
        tick(1);
        check("ord_second_valid", 32'(evt_valid), 32'h1);
        check("ord_second_idx", 32'(evt_idx), 32'h5);
        tick(1);
        check("ord_empty", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;
        sw = '0;
        tick(10);

        // overflow
        sw[1] = 1'b1; tick(8);
        check("ovf_before", 32'(evt_overflow), 32'h0);
        sw[1] = 1'b0; tick(8);
        sw[1] = 1'b1; tick(8);
        check("ovf_valid", 32'(evt_valid), 32'h1);
        check("ovf_idx", 32'(evt_idx), 32'h1);
        check("ovf_flag", 32'(evt_overflow), 32'h1);
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        check("ovf_drained", 32'(evt_valid), 32'h0);
        sw[1] = 1'b0; tick(10);
        check("ovf_sticky", 32'(evt_overflow), 32'h1);

        // reset mid-operation
        sw = 8'h14; tick(8);
        check("pre_rst_valid", 32'(evt_valid), 32'h1);
        check("pre_rst_idx", 32'(evt_idx), 32'h2);
        sw = 8'h94; tick(4);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_level", 32'(sw_level), 32'h0);
        check("mid_rst_valid", 32'(evt_valid), 32'h0);
        check("mid_rst_idx", 32'(evt_idx), 32'h0);
        check("mid_rst_overflow", 32'(evt_overflow), 32'h0);
        sw = 8'h80;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick(5);
        check("post_rst_press_early", 32'(sw_press), 32'h00);
        check("post_rst_valid_early", 32'(evt_valid), 32'h0);
        tick(1);
        check("post_rst_press", 32'(sw_press), 32'h80);
        tick(1);
        check("post_rst_idx", 32'(evt_idx), 32'h7);
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        sw = '0; tick(10);

        // hold behaviour
        evt_times.delete();
        cyc = 0;
        evt_ready = 1'b1;
        sw[4] = 1'b1;
        tick(48);
`ifdef SWITCH_EVT_AUTOREPEAT_EN
        check("rpt_count", 32'(evt_times.size()), 32'd6);
        if (evt_times.size() >= 3) begin
            check("rpt_first", 32'(evt_times[0]), 32'd7);
            check("rpt_delay", 32'(evt_times[1] - evt_times[0]), 32'd20);
            check("rpt_period", 32'(evt_times[2] - evt_times[1]), 32'd5);
        end
`else
        check("hold_count", 32'(evt_times.size()), 32'd1);
        if (evt_times.size() >= 1) check("hold_first", 32'(evt_times[0]), 32'd7);
`endif
        sw[4] = 1'b0;
        tick(20);
        evt_times.delete();
        tick(20);
        check("hold_released", 32'(evt_times.size()), 32'd0);
        evt_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
